// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// cpu_bus_pkg: default M2 timing and bus-cycle phase encoding shared by the CPU bus master.
package cpu_bus_pkg;

  localparam int DEF_TICKS_LOW  = 6;
  localparam int DEF_TICKS_HIGH = 6;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    LOW     = 2'd1,
    HIGH    = 2'd2,
    STOPPED = 2'd3
  } phase_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
  } bus_req_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// sync_2ff: two-flop synchronizer with a selectable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_bus_master.sv
`default_nettype none
// cpu_bus_master: generates M2 bus cycles toward a cartridge and runs one queued host
// request per cycle (one-entry request slot, one-clk response pulse).
module cpu_bus_master
  import cpu_bus_pkg::*;
#(
  parameter int TICKS_LOW  = DEF_TICKS_LOW,
  parameter int TICKS_HIGH = DEF_TICKS_HIGH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_rw,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in,
  input  logic        irq,
  output logic        irq_sync
);

  localparam int N  = TICKS_LOW + TICKS_HIGH;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_ONE        = CW'(1);
  localparam logic [CW-1:0] CNT_FIRST_HIGH = CW'(TICKS_LOW);
  localparam logic [CW-1:0] CNT_LAST       = CW'(N - 1);

  phase_t        phase, phase_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          slot_v, slot_v_nxt;
  bus_req_t      slot, slot_nxt, incoming, new_req;
  logic          act_v, act_v_nxt;
  logic          act_rw, act_rw_nxt;
  logic          act_a15, act_a15_nxt;
  logic [7:0]    act_wd, act_wd_nxt;
  logic          m2_nxt, romsel_nxt, cpu_rw_nxt, oe_nxt, rsp_valid_nxt;
  logic [14:0]   addr_nxt;
  logic [7:0]    dout_nxt, rdata_nxt;
  logic          accept;

  assign req_ready = !slot_v;

  always_comb begin
    phase_nxt     = phase;
    cnt_nxt       = cnt;
    slot_v_nxt    = slot_v;
    slot_nxt      = slot;
    act_v_nxt     = act_v;
    act_rw_nxt    = act_rw;
    act_a15_nxt   = act_a15;
    act_wd_nxt    = act_wd;
    m2_nxt        = m2;
    cpu_rw_nxt    = cpu_rw;
    addr_nxt      = cpu_addr;
    oe_nxt        = cpu_data_oe;
    dout_nxt      = cpu_data_out;
    rsp_valid_nxt = 1'b0;
    rdata_nxt     = rsp_rdata;
    accept        = req_valid && !slot_v;
    incoming      = '{addr: req_addr, rw: req_rw, wdata: req_wdata};
    new_req       = slot_v ? slot : incoming;

    if (accept) begin
      slot_v_nxt = 1'b1;
      slot_nxt   = incoming;
    end

    case (phase)
      HOLD, STOPPED: begin
        if (run) begin
          // Activation edge: a request handshaking right now bypasses the slot.
          phase_nxt  = LOW;
          cnt_nxt    = CNT_ONE;
          slot_v_nxt = 1'b0;
          act_v_nxt  = slot_v || req_valid;
          if (slot_v || req_valid) begin
            act_rw_nxt  = new_req.rw;
            act_a15_nxt = new_req.addr[15];
            act_wd_nxt  = new_req.wdata;
            addr_nxt    = new_req.addr[14:0];
            cpu_rw_nxt  = new_req.rw;
            oe_nxt      = cpu_data_oe && !new_req.rw;
          end else begin
            cpu_rw_nxt = 1'b1;
            oe_nxt     = 1'b0;
          end
        end else begin
          phase_nxt  = STOPPED;
          act_v_nxt  = 1'b0;
          cpu_rw_nxt = 1'b1;
          oe_nxt     = 1'b0;
        end
      end
      LOW: begin
        cnt_nxt = cnt + CNT_ONE;
        if (cnt_nxt == CNT_FIRST_HIGH) begin
          phase_nxt = HIGH;
          m2_nxt    = 1'b1;
          if (act_v && !act_rw) begin
            oe_nxt   = 1'b1;
            dout_nxt = act_wd;
          end
        end
      end
      HIGH: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt       = '0;
          phase_nxt     = HOLD;
          m2_nxt        = 1'b0;
          rsp_valid_nxt = act_v;
          if (act_v) begin
            rdata_nxt = act_rw ? cpu_data_in : 8'h00;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        phase_nxt = STOPPED;
        cnt_nxt   = '0;
      end
    endcase

    romsel_nxt = !(m2_nxt && act_v_nxt && act_a15_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= STOPPED;
      cnt          <= '0;
      slot_v       <= 1'b0;
      slot         <= '0;
      act_v        <= 1'b0;
      act_rw       <= 1'b1;
      act_a15      <= 1'b0;
      act_wd       <= 8'h00;
      m2           <= 1'b0;
      romsel       <= 1'b1;
      cpu_rw       <= 1'b1;
      cpu_addr     <= '0;
      cpu_data_out <= 8'h00;
      cpu_data_oe  <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 8'h00;
    end else begin
      phase        <= phase_nxt;
      cnt          <= cnt_nxt;
      slot_v       <= slot_v_nxt;
      slot         <= slot_nxt;
      act_v        <= act_v_nxt;
      act_rw       <= act_rw_nxt;
      act_a15      <= act_a15_nxt;
      act_wd       <= act_wd_nxt;
      m2           <= m2_nxt;
      romsel       <= romsel_nxt;
      cpu_rw       <= cpu_rw_nxt;
      cpu_addr     <= addr_nxt;
      cpu_data_out <= dout_nxt;
      cpu_data_oe  <= oe_nxt;
      rsp_valid    <= rsp_valid_nxt;
      rsp_rdata    <= rdata_nxt;
    end
  end

  sync_2ff #(.RESET_VAL(1'b1)) u_irq_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq),
    .q     (irq_sync)
  );

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_master.sv
`default_nettype none
// tb_cpu_bus_master: directed requests checked every cycle against a transaction-level model
// of the bus cycle, plus literal expectations for the headline scenarios.
module tb_cpu_bus_master;

  localparam int TL = 6;
  localparam int TH = 6;
  localparam int N  = TL + TH;

  logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0, irq = 1'b1;
  logic        req_valid = 1'b0, req_rw = 1'b1;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00, cpu_data_in = 8'hEE, cart_byte = 8'h00;
  logic        req_ready, rsp_valid, m2, romsel, cpu_rw, cpu_data_oe, irq_sync;
  logic [7:0]  rsp_rdata, cpu_data_out;
  logic [14:0] cpu_addr;
  int          tests = 0, fails = 0;

  cpu_bus_master #(.TICKS_LOW(TL), .TICKS_HIGH(TH)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rw(req_rw), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .m2(m2), .romsel(romsel), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe), .cpu_data_in(cpu_data_in),
    .irq(irq), .irq_sync(irq_sync)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, got, want);
    end
  endtask

  // Model: one record per bus cycle; outputs follow from position in the cycle and the
  // transaction of this cycle and the one before it.
  typedef struct packed { logic v; logic rw; logic [15:0] a; logic [7:0] wd; } txn_t;
  txn_t        m_cur = '0, m_prev = '0, m_slot = '0;
  bit          m_slot_v = 1'b0, m_stopped = 1'b1, hs;
  int          m_pos = 0;
  logic [14:0] m_addr = '0;
  logic [7:0]  m_dout = 8'h00, m_rd = 8'h00;
  logic [1:0]  m_irq = 2'b11;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cur = '0; m_prev = '0; m_slot = '0; m_slot_v = 1'b0; m_stopped = 1'b1;
      m_pos = 0; m_addr = '0; m_dout = 8'h00; m_rd = 8'h00; m_irq = 2'b11;
    end else begin
      hs = req_valid && !m_slot_v;
      if (m_pos == 0 && run) begin
        m_prev = m_cur; m_stopped = 1'b0; m_pos = 1;
        if (m_slot_v) begin m_cur = m_slot; m_slot_v = 1'b0; end
        else if (hs) m_cur = {1'b1, req_rw, req_addr, req_wdata};
        else m_cur = '0;
        if (m_cur.v) m_addr = m_cur.a[14:0];
      end else begin
        if (m_pos == 0 && !m_stopped) begin m_stopped = 1'b1; m_cur = '0; m_prev = '0; end
        if (hs) begin m_slot = {1'b1, req_rw, req_addr, req_wdata}; m_slot_v = 1'b1; end
        if (m_pos == N - 1) begin
          if (m_cur.v && m_cur.rw) m_rd = cpu_data_in;
          m_pos = 0;
        end else if (m_pos != 0) begin
          m_pos++;
          if (m_pos == TL && m_cur.v && !m_cur.rw) m_dout = m_cur.wd;
        end
      end
      m_irq = {m_irq[0], irq};
    end
  end

  // Cartridge: valid read data only on the last m2-high tick.
  initial forever begin
    @(negedge clk);
    cpu_data_in = (!m_stopped && m_pos == N - 1) ? cart_byte : 8'hEE;
  end

  initial forever begin : compare
    logic e_m2, e_oe, e_rsp;
    @(negedge clk);
    e_m2  = !m_stopped && m_pos >= TL;
    e_oe  = !m_stopped && m_cur.v && !m_cur.rw &&
            (m_pos >= TL || m_pos == 0 || (m_prev.v && !m_prev.rw));
    e_rsp = !m_stopped && m_pos == 0 && m_cur.v;
    check("m2", m2, e_m2);
    check("romsel", romsel, !(e_m2 && m_cur.v && m_cur.a[15]));
    check("cpu_rw", cpu_rw, m_stopped ? 1'b1 : (m_cur.v ? m_cur.rw : 1'b1));
    check("cpu_addr", cpu_addr, m_addr);
    check("cpu_data_oe", cpu_data_oe, e_oe);
    check("cpu_data_out", cpu_data_out, m_dout);
    check("req_ready", req_ready, !m_slot_v);
    check("rsp_valid", rsp_valid, e_rsp);
    if (e_rsp) check("rsp_rdata", rsp_rdata, m_cur.rw ? m_rd : 8'h00);
    check("irq_sync", irq_sync, m_irq[1]);
  end

  int          cyc = 0, m2_hi = 0, rlow = 0, oe_hi = 0, rw_lo = 0;
  logic [14:0] rlow_addr = '0;
  logic        m2_q = 1'b0;
  int          rise_q[$], rsp_cyc[$];
  logic [7:0]  rsp_dat[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (m2) m2_hi++;
    if (m2 && !m2_q) rise_q.push_back(cyc);
    m2_q = m2;
    if (!romsel) begin rlow++; rlow_addr = cpu_addr; end
    if (cpu_data_oe) oe_hi++;
    if (!cpu_rw) rw_lo++;
    if (rsp_valid) begin rsp_cyc.push_back(cyc); rsp_dat.push_back(rsp_rdata); end
  end

  task automatic send(input logic [15:0] a, input logic rw, input logic [7:0] wd);
    int n = 0;
    @(negedge clk);
    req_addr = a; req_rw = rw; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check("send_timeout", n < 100, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_active(input logic rw, input int pos);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(m_cur.v && m_cur.rw == rw && m_pos == pos && !m_stopped) && n < 200);
    check("wait_timeout", n < 200, 1'b1);
  endtask

  initial begin
    int s_m2, s_rsp, s_rlow, s_oe, s_rw;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m2", m2, 1'b0);
    check("rst_romsel", romsel, 1'b1);
    check("rst_cpu_rw", cpu_rw, 1'b1);
    check("rst_cpu_addr", cpu_addr, 15'h0000);
    check("rst_data_out", cpu_data_out, 8'h00);
    check("rst_data_oe", cpu_data_oe, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 8'h00);
    check("rst_irq_sync", irq_sync, 1'b1);
    @(negedge clk) begin rst_n = 1'b1; run = 1'b1; end

    // Idle running, with an irq excursion.
    repeat (40) @(posedge clk);
    s_m2 = m2_hi; s_rsp = rsp_cyc.size(); s_rlow = rlow;
    @(negedge clk) irq = 1'b0;
    @(negedge clk) check("irq_delay1", irq_sync, 1'b1);
    @(negedge clk) check("irq_delay2", irq_sync, 1'b0);
    irq = 1'b1;
    repeat (34) @(posedge clk);
    check("idle_m2_high_ticks", m2_hi - s_m2, 18);
    check("idle_m2_period", rise_q[$] - rise_q[$-1], 12);
    check("idle_no_rsp", rsp_cyc.size() - s_rsp, 0);
    check("idle_romsel", rlow - s_rlow, 0);

    // Read $8123 from cartridge returning $A5.
    cart_byte = 8'hA5; s_rsp = rsp_cyc.size(); s_rlow = rlow;
    send(16'h8123, 1'b1, 8'h00);
    repeat (30) @(posedge clk);
    check("rd_romsel_ticks", rlow - s_rlow, 6);
    check("rd_addr", rlow_addr, 15'h0123);
    check("rd_rsp_count", rsp_cyc.size() - s_rsp, 1);
    check("rd_rdata", rsp_dat[$], 8'hA5);

    // Write $6000 = $3C.
    s_rsp = rsp_cyc.size(); s_rlow = rlow; s_oe = oe_hi; s_rw = rw_lo;
    send(16'h6000, 1'b0, 8'h3C);
    repeat (30) @(posedge clk);
    check("wr_oe_ticks", oe_hi - s_oe, 7);
    check("wr_rw_low_ticks", rw_lo - s_rw, 12);
    check("wr_romsel", rlow - s_rlow, 0);
    check("wr_rsp_count", rsp_cyc.size() - s_rsp, 1);
    check("wr_rdata", rsp_dat[$], 8'h00);
    check("wr_data_out", cpu_data_out, 8'h3C);

    // Back-to-back: two writes then a read.
    cart_byte = 8'h5A; s_rsp = rsp_cyc.size();
    send(16'h6001, 1'b0, 8'h11);
    send(16'h6002, 1'b0, 8'h22);
    send(16'h8004, 1'b1, 8'h00);
    repeat (40) @(posedge clk);
    check("b2b_rsp_count", rsp_cyc.size() - s_rsp, 3);
    check("b2b_rdata0", rsp_dat[s_rsp], 8'h00);
    check("b2b_rdata1", rsp_dat[s_rsp+1], 8'h00);
    check("b2b_rdata2", rsp_dat[s_rsp+2], 8'h5A);
    check("b2b_gap01", rsp_cyc[s_rsp+1] - rsp_cyc[s_rsp], 12);
    check("b2b_gap12", rsp_cyc[s_rsp+2] - rsp_cyc[s_rsp+1], 12);

    // run dropped at count 8 of a read; a write queued while stopped.
    cart_byte = 8'h77; s_rsp = rsp_cyc.size();
    send(16'hC000, 1'b1, 8'h00);
    wait_active(1'b1, 8);
    run = 1'b0;
    send(16'h6010, 1'b0, 8'h99);
    repeat (8) @(posedge clk);
    s_m2 = m2_hi;
    repeat (24) @(posedge clk);
    check("stop_m2_quiet", m2_hi - s_m2, 0);
    check("stop_rsp_count", rsp_cyc.size() - s_rsp, 1);
    check("stop_rdata", rsp_dat[$], 8'h77);
    check("stop_queued", req_ready, 1'b0);
    @(negedge clk) run = 1'b1;
    repeat (30) @(posedge clk);
    check("resume_rsp_count", rsp_cyc.size() - s_rsp, 2);
    check("resume_rdata", rsp_dat[$], 8'h00);

    // Asynchronous reset in the middle of a write's m2-high phase.
    s_rsp = rsp_cyc.size();
    send(16'h6020, 1'b0, 8'h55);
    wait_active(1'b0, TL + 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_m2", m2, 1'b0);
    check("arst_oe", cpu_data_oe, 1'b0);
    check("arst_romsel", romsel, 1'b1);
    check("arst_rw", cpu_rw, 1'b1);
    check("arst_rsp_valid", rsp_valid, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (30) @(posedge clk);
    check("arst_no_rsp", rsp_cyc.size() - s_rsp, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
